// File: rtl/vfifo_stream_reader.sv
// Drains a versatile-FIFO read port (1-cycle read latency) into a valid/ready stream via a 2-entry skid buffer.
// Optional `VFIFO_READER_LAST_EN: top FIFO bit is end-of-packet -> m_last, and DRAIN stops on a packet boundary.
module vfifo_stream_reader #(
  parameter int data_width = 18,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [data_width-1:0] fifo_q,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
`ifdef VFIFO_READER_LAST_EN
  output logic [data_width-2:0] m_data,
  output logic                  m_last,
`else
  output logic [data_width-1:0] m_data,
`endif
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [cnt_width-1:0]  word_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q;
  logic [data_width-1:0] head_q, head_d, tail_q, tail_d;
  logic [cnt_width-1:0]  cnt_q;
  logic                  pop, push, space, fetch_ok, drain_done;
  logic [2:0]            occ;

  assign m_valid = (count_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign push    = inflight_q;
  // Occupancy after this cycle's pop, counting the word already on its way from the DPRAM.
  assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign space   = (occ < 3'd2);

`ifdef VFIFO_READER_LAST_EN
  logic bound_q, bound_d, bound_now;

  // At a packet boundary when the newest fetched word carried last=1.
  assign bound_now  = inflight_q ? fifo_q[data_width-1] : bound_q;
  assign fetch_ok   = (state_q == RUN) | ((state_q == DRAIN) & ~bound_now);
  assign drain_done = (count_q == 2'd0) & ~inflight_q & bound_q;
  assign m_data     = head_q[data_width-2:0];
  assign m_last     = head_q[data_width-1];

  always_comb begin
    bound_d = bound_q;
    if (push) bound_d = fifo_q[data_width-1];
    if (flush) bound_d = 1'b1;
  end
`else
  assign fetch_ok   = (state_q == RUN);
  assign drain_done = (count_q == 2'd0) & ~inflight_q;
  assign m_data     = head_q;
`endif

  assign fifo_rd  = ~rst & fetch_ok & ~fifo_empty & ~flush & space;
  assign busy     = (state_q != IDLE) | (count_q != 2'd0) | inflight_q;
  assign word_cnt = cnt_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = fifo_q;
        else                 tail_d = fifo_q;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) head_d = fifo_q;
        else begin
          head_d = tail_q;
          tail_d = fifo_q;
        end
      end
      default: ;
    endcase
    // The captured in-flight word is discarded along with the buffer.
    if (flush) count_d = 2'd0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)          state_d = RUN;
        else if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
`ifdef VFIFO_READER_LAST_EN
      bound_q    <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      inflight_q <= fifo_rd;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_q + cnt_width'(pop);
`ifdef VFIFO_READER_LAST_EN
      bound_q    <= bound_d;
`endif
    end
  end

endmodule

// File: tb/tb_vfifo_stream_reader.sv
// Bench for vfifo_stream_reader: queue-based FIFO model with 1-cycle read data, stream scoreboard, scenario tasks.
module tb_vfifo_stream_reader;
  localparam int DW = 18;
  localparam int CW = 16;
`ifdef VFIFO_READER_LAST_EN
  localparam int MW = DW - 1;
`else
  localparam int MW = DW;
`endif

  logic          clk = 1'b0;
  logic          rst, enable, flush, fifo_empty, fifo_rd, m_valid, m_ready, busy;
  logic [DW-1:0] fifo_q;
  logic [MW-1:0] m_data;
  logic [CW-1:0] word_cnt;
`ifdef VFIFO_READER_LAST_EN
  logic          m_last;
`endif

  vfifo_stream_reader #(.data_width(DW), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .m_data(m_data),
`ifdef VFIFO_READER_LAST_EN
    .m_last(m_last),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] fq[$];      // words still in the FIFO
  logic [DW-1:0] exp_q[$];   // words fetched but not yet delivered
  logic [MW-1:0] got[$];
  logic          got_last[$];
  int            rd_count = 0;
  logic [CW-1:0] tb_cnt = '0;

  logic          rd_s = 1'b0, pop_s = 1'b0, flush_s = 1'b0, rst_s = 1'b1, hold_s = 1'b0, last_s = 1'b0;
  logic [MW-1:0] data_s = '0, hdata_s = '0;

  function automatic logic [MW-1:0] dpart(input logic [DW-1:0] w);
    return w[MW-1:0];
  endfunction

  // Sample between edges; the FIFO model and scoreboard act on these at the next posedge.
  always @(negedge clk) begin
    if (hold_s) begin
      n_checks++;
      if (!m_valid || m_data !== hdata_s)
        $display("FAIL stall_hold: valid=%0b data=%0h required valid=1 data=%0h", m_valid, m_data, hdata_s);
      else n_pass++;
    end
    n_checks++;
    if (fifo_rd && fifo_empty) $display("FAIL rd_on_empty: fifo_rd=1 while fifo_empty=1");
    else n_pass++;
    n_checks++;
    if (exp_q.size() > 2) $display("FAIL overflow: outstanding=%0d required <=2", exp_q.size());
    else n_pass++;
    rd_s    = fifo_rd;
    pop_s   = m_valid & m_ready;
    flush_s = flush;
    rst_s   = rst;
    data_s  = m_data;
`ifdef VFIFO_READER_LAST_EN
    last_s  = m_last;
`endif
    hold_s  = m_valid & ~m_ready & ~flush & ~rst;
    hdata_s = m_data;
  end

  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (rst_s) begin
      exp_q.delete();
      tb_cnt = '0;
    end else begin
      if (pop_s) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL underflow: pop with nothing fetched");
        else begin
          w = exp_q.pop_front();
`ifdef VFIFO_READER_LAST_EN
          if (data_s !== dpart(w) || last_s !== w[DW-1])
            $display("FAIL stream_word: got %0h/%0b required %0h/%0b", data_s, last_s, dpart(w), w[DW-1]);
`else
          if (data_s !== dpart(w))
            $display("FAIL stream_word: got %0h required %0h", data_s, dpart(w));
`endif
          else n_pass++;
        end
        got.push_back(data_s);
        got_last.push_back(last_s);
        tb_cnt++;
      end
      if (flush_s) exp_q.delete();
      if (rd_s && fq.size() != 0) begin
        w = fq.pop_front();
        fifo_q <= w;
        exp_q.push_back(w);
        rd_count++;
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fq.delete(); fifo_empty = 1'b1; fifo_q = '0;
    tick(); tick();
    rst = 1'b0;
    got.delete(); got_last.delete(); rd_count = 0;
  endtask

  task automatic load(input logic [DW-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    load(18'h00abc);
    enable = 1'b1; m_ready = 1'b1;
    tick();
    #1;
    n_checks++;
    if (fifo_rd !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_ctl: rd=%0b valid=%0b busy=%0b required 0/0/0", fifo_rd, m_valid, busy);
    else n_pass++;
    n_checks++;
    if (m_data !== '0 || word_cnt !== '0)
      $display("FAIL reset_data: data=%0h cnt=%0h required 0/0", m_data, word_cnt);
    else n_pass++;
`ifdef VFIFO_READER_LAST_EN
    n_checks++;
    if (m_last !== 1'b0) $display("FAIL reset_last: got %0b required 0", m_last);
    else n_pass++;
`endif
  endtask

  task automatic test_first_word();
    logic rd[6], vl[6];
    logic [MW-1:0] dt[6];
    logic exp_rd[6] = '{0, 1, 1, 0, 0, 0};
    logic exp_vl[6] = '{0, 0, 0, 1, 1, 0};
    do_reset();
    load(18'h00001); load(18'h00002);
    enable = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      rd[k] = fifo_rd; vl[k] = m_valid; dt[k] = m_data;
      if (k < 5) tick();
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (rd[k] !== exp_rd[k] || vl[k] !== exp_vl[k])
        $display("FAIL latency_c%0d: rd=%0b valid=%0b required rd=%0b valid=%0b", k, rd[k], vl[k], exp_rd[k], exp_vl[k]);
      else n_pass++;
    end
    n_checks++;
    if (dt[3] !== MW'(1) || dt[4] !== MW'(2))
      $display("FAIL latency_data: got %0h,%0h required 1,2", dt[3], dt[4]);
    else n_pass++;
    n_checks++;
    if (word_cnt !== 16'd2) $display("FAIL latency_cnt: got %0d required 2", word_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[8];
    do_reset();
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w[i] = DW'($urandom());
      load(w[i]);
    end
    for (int k = 0; k < 10; k++) tick();
    n_checks++;
    if (rd_count !== 2) $display("FAIL stall_reads: got %0d required 2", rd_count);
    else n_pass++;
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== dpart(w[0]))
      $display("FAIL stall_head: valid=%0b data=%0h required 1/%0h", m_valid, m_data, dpart(w[0]));
    else n_pass++;
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    n_checks++;
    if (got.size() !== 8) $display("FAIL release_gapless: got %0d words in 8 cycles required 8", got.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== dpart(w[i])) $display("FAIL release_order%0d: got %0h required %0h", i, got[i], dpart(w[i]));
      else n_pass++;
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] wd;
    int got0, owed, k;
    logic seen;
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wd = DW'($urandom());
`ifdef VFIFO_READER_LAST_EN
      wd[DW-1] = 1'b1;
`endif
      load(wd);
    end
    seen = 1'b0;
    for (k = 0; k < 12 && !seen; k++) begin
      tick(); #1;
      seen = m_valid & fifo_rd;
    end
    n_checks++;
    if (!seen) $display("FAIL drain_steady: no streaming cycle within 12 cycles");
    else n_pass++;
    got0 = got.size();
    owed = exp_q.size() + 1;
    enable = 1'b0;
    n_checks++;
    if (owed !== 3) $display("FAIL drain_owed: outstanding %0d required 3", owed);
    else n_pass++;
    seen = 1'b0;
    for (k = 0; k < 12 && !seen; k++) begin
      tick(); #1;
      seen = ~busy;
    end
    n_checks++;
    if (!seen || got.size() !== got0 + 3)
      $display("FAIL drain_busy: idle=%0b delivered=%0d required idle after %0d", seen, got.size() - got0, 3);
    else n_pass++;
    for (k = 0; k < 5; k++) tick();
    n_checks++;
    if (fq.size() !== 6 - rd_count || rd_count !== got.size() || busy !== 1'b0)
      $display("FAIL drain_stop: fetched=%0d delivered=%0d left=%0d busy=%0b", rd_count, got.size(), fq.size(), busy);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [DW-1:0] w[8];
    int k;
    do_reset();
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w[i] = DW'($urandom());
      load(w[i]);
    end
    for (k = 0; k < 10 && rd_count < 2; k++) tick();
    n_checks++;
    if (rd_count !== 2 || exp_q.size() !== 2)
      $display("FAIL flush_setup: fetched=%0d outstanding=%0d required 2/2", rd_count, exp_q.size());
    else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL flush_clear: valid=%0b busy=%0b required 0/0", m_valid, busy);
    else n_pass++;
    m_ready = 1'b1;
    for (k = 0; k < 15; k++) tick();
    n_checks++;
    if (got.size() !== 6) $display("FAIL flush_count: got %0d words required 6", got.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== dpart(w[i+2])) $display("FAIL flush_order%0d: got %0h required %0h", i, got[i], dpart(w[i+2]));
      else n_pass++;
    end
    n_checks++;
    if (word_cnt !== 16'd6) $display("FAIL flush_cnt: got %0d required 6", word_cnt);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int k;
    do_reset();
    for (int i = 0; i < 65540; i++) fq.push_back(DW'($urandom()));
    fifo_empty = 1'b0;
    enable = 1'b1; m_ready = 1'b1;
    for (k = 0; k < 70000 && tb_cnt != 16'hFFFF; k++) tick();
    m_ready = 1'b0;
    #1;
    n_checks++;
    if (word_cnt !== 16'hFFFF) $display("FAIL wrap_max: got %0h required ffff", word_cnt);
    else n_pass++;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    n_checks++;
    if (word_cnt !== 16'h0000) $display("FAIL wrap_zero: got %0h required 0000", word_cnt);
    else n_pass++;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (word_cnt !== 16'h0001) $display("FAIL cnt_survives_flush: got %0h required 0001", word_cnt);
    else n_pass++;
  endtask

`ifdef VFIFO_READER_LAST_EN
  task automatic test_last();
    logic [DW-1:0] p[5];
    logic          lb[5] = '{0, 0, 1, 0, 1};
    int k;
    do_reset();
    m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p[i] = DW'($urandom());
      p[i][DW-1] = lb[i];
      load(p[i]);
    end
    for (k = 0; k < 10 && rd_count < 1; k++) tick();
    enable = 1'b0;
    for (k = 0; k < 12; k++) tick();
    n_checks++;
    if (got.size() !== 3 || fq.size() !== 2 || rd_count !== 3)
      $display("FAIL pkt_stop: delivered=%0d fetched=%0d left=%0d required 3/3/2", got.size(), rd_count, fq.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== dpart(p[i]) || got_last[i] !== lb[i])
        $display("FAIL pkt_word%0d: got %0h/%0b required %0h/%0b", i, got[i], got_last[i], dpart(p[i]), lb[i]);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL pkt_idle: busy=%0b required 0", busy);
    else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_q = '0;
    test_reset();
    test_first_word();
    test_backpressure();
    test_drain();
    test_flush();
`ifdef VFIFO_READER_LAST_EN
    test_last();
`endif
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
